dds_button_pio: RTL

//  Parametrised Avalon-MM input PIO for the front-panel buttons of the DDS generator (CH ON/OFF, menu, encoder push).

---
 rtl/dds_pio_pkg.sv | 18 +
 rtl/dds_debounce_ch.sv | 65 ++++++
 rtl/dds_button_pio.sv | 109 ++++++++++
 3 files changed

// File: rtl/dds_pio_pkg.sv
// Shared constants for the DDS front-panel button PIO: register map and helpers.
package dds_pio_pkg;

  localparam int PIO_ADDR_W = 3;

  localparam logic [PIO_ADDR_W-1:0] ADDR_DATA    = 3'd0;
  localparam logic [PIO_ADDR_W-1:0] ADDR_RAW     = 3'd1;
  localparam logic [PIO_ADDR_W-1:0] ADDR_MASK    = 3'd2;
  localparam logic [PIO_ADDR_W-1:0] ADDR_EDGE    = 3'd3;
  localparam logic [PIO_ADDR_W-1:0] ADDR_RISE_EN = 3'd4;
  localparam logic [PIO_ADDR_W-1:0] ADDR_FALL_EN = 3'd5;

  // Debounce counter width; a single-cycle debounce still gets a 1-bit type.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/dds_debounce_ch.sv
// One button channel: 2-FF synchroniser followed by a stable-for-N-cycles debouncer.
module dds_debounce_ch
  import dds_pio_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic RESET_BIT       = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic raw,
  output logic deb
);

  logic sync1_r;
  logic sync2_r;
  logic deb_r;

  // Two-stage synchroniser for the asynchronous button input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= RESET_BIT;
      sync2_r <= RESET_BIT;
    end else begin
      sync1_r <= din;
      sync2_r <= sync1_r;
    end
  end

  generate
    if (DEBOUNCE_CYCLES <= 1) begin : g_nodeb
      // Debounce disabled: the debounced state trails raw by one cycle.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          deb_r <= RESET_BIT;
        end else begin
          deb_r <= sync2_r;
        end
      end
    end else begin : g_deb
      localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
      localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
      logic [CNT_W-1:0] cnt_r;

      // Any return to the current state restarts the count, so glitches never accumulate.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_r <= '0;
          deb_r <= RESET_BIT;
        end else if (sync2_r == deb_r) begin
          cnt_r <= '0;
        end else if (cnt_r == TERM) begin
          cnt_r <= '0;
          deb_r <= sync2_r;
        end else begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
      end
    end
  endgenerate

  assign raw = sync2_r;
  assign deb = deb_r;

endmodule

// File: rtl/dds_button_pio.sv
// Avalon-MM input PIO for the DDS front-panel buttons: debounce, edge capture (W1C) and maskable IRQ.
module dds_button_pio
  import dds_pio_pkg::*;
#(
  parameter int               WIDTH           = 2,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0] RESET_LEVEL     = {WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [PIO_ADDR_W-1:0] address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [WIDTH-1:0]      in_port,
  output logic                  irq
);

  logic [WIDTH-1:0] raw_s;
  logic [WIDTH-1:0] deb_s;
  logic [WIDTH-1:0] deb_d_r;
  logic [WIDTH-1:0] mask_r;
  logic [WIDTH-1:0] edge_r;
  logic [WIDTH-1:0] rise_en_r;
  logic [WIDTH-1:0] fall_en_r;
  logic [WIDTH-1:0] ev_s;
  logic [WIDTH-1:0] clr_s;
  logic [WIDTH-1:0] wdata_s;
  logic             wr_s;
  logic [31:0]      rd_s;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    dds_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_BIT      (RESET_LEVEL[i])
    ) u_ch (
      .clk    (clk),
      .reset_n(reset_n),
      .din    (in_port[i]),
      .raw    (raw_s[i]),
      .deb    (deb_s[i])
    );
  end

  assign wr_s         = chipselect && !write_n;
  assign wdata_s      = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  // Qualified edge events and the write-1-to-clear pattern for this cycle.
  always_comb begin
    ev_s = ((deb_s & ~deb_d_r) & rise_en_r) | ((~deb_s & deb_d_r) & fall_en_r);
    if (wr_s && (address == ADDR_EDGE)) begin
      clr_s = wdata_s;
    end else begin
      clr_s = '0;
    end
  end

  // Previous debounced state; reset to the idle level so reset release makes no edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_d_r <= RESET_LEVEL;
    end else begin
      deb_d_r <= deb_s;
    end
  end

  // Register file; a new event outranks a simultaneous clear so no press is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_r    <= '0;
      rise_en_r <= '0;
      fall_en_r <= {WIDTH{1'b1}};
      edge_r    <= '0;
    end else begin
      if (wr_s && (address == ADDR_MASK)) mask_r <= wdata_s;
      if (wr_s && (address == ADDR_RISE_EN)) rise_en_r <= wdata_s;
      if (wr_s && (address == ADDR_FALL_EN)) fall_en_r <= wdata_s;
      edge_r <= (edge_r & ~clr_s) | ev_s;
    end
  end

  // Read mux, unqualified by chipselect.
  always_comb begin
    case (address)
      ADDR_DATA:    rd_s = 32'(deb_s);
      ADDR_RAW:     rd_s = 32'(raw_s);
      ADDR_MASK:    rd_s = 32'(mask_r);
      ADDR_EDGE:    rd_s = 32'(edge_r);
      ADDR_RISE_EN: rd_s = 32'(rise_en_r);
      ADDR_FALL_EN: rd_s = 32'(fall_en_r);
      default:      rd_s = 32'h0000_0000;
    endcase
  end

  // Registered read data, one cycle of latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= 32'h0000_0000;
    end else begin
      readdata <= rd_s;
    end
  end

  assign irq = |(edge_r & mask_r);

endmodule
